snn_run_sequencer: RTL and testbench

Batch-run controller for the SNN core. For each of N samples it clears the network and spike counters, enables the network for sim_time cycles, then scans the per-output spike counters for the winning neuron. It pushes {sample index, winner, count} into a result FIFO drained by the AXI register block. It replaces single-shot software control of network reset and enable with a hardware loop, and tells the spike generator when to advance to the next sample.

---
 rtl/snn_seq_pkg.sv | 33 +++
 rtl/seq_result_fifo.sv | 54 +++++
 rtl/snn_run_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_snn_run_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
// snn_seq_pkg: shared types for the SNN batch-run sequencer.
// Holds the sequencer state encoding, the default result-entry layout and
// the winner-index width helper.
package snn_seq_pkg;

    localparam int unsigned SEQ_NUM_OUTPUTS  = 1;
    localparam int unsigned SEQ_COUNTER_SIZE = 32;
    localparam int unsigned SEQ_SAMPLE_W     = 16;

    // Index width that never collapses to zero bits for a single output.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned SEQ_WINNER_W = clog2_min1(SEQ_NUM_OUTPUTS);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SCAN,
        PUSH,
        NEXT,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_SAMPLE_W-1:0]     sample;
        logic [SEQ_WINNER_W-1:0]     winner;
        logic [SEQ_COUNTER_SIZE-1:0] count;
    } seq_result_t;

endpackage

// File: rtl/seq_result_fifo.sv
// seq_result_fifo: synchronous show-ahead FIFO of sequencer result entries.
// The head entry is presented combinationally; a write into a full FIFO is
// accepted when a read frees a slot in the same cycle.
module seq_result_fifo
    import snn_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = seq_result_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   wr_en,
    input  entry_t wr_data,
    input  logic   rd_en,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_wr;
    logic          do_rd;

    // Extra pointer bit distinguishes full from empty.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd   = rd_en && !empty;
        do_wr   = wr_en && (!full || do_rd);
        rd_data = mem[rd_ptr_q[AW-1:0]];
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/snn_run_sequencer.sv
// snn_run_sequencer: hardware batch loop for the SNN core. Per sample it
// clears the network, runs it for sim_time cycles, scans the spike counters
// for the winner and queues {sample, winner, count} in a result FIFO.
// Optional build macro SNN_SEQ_PERF_EN adds the stall_cycles counter port.
module snn_run_sequencer
    import snn_seq_pkg::*;
#(
    parameter int unsigned NUM_OUTPUTS   = 1,
    parameter int unsigned COUNTER_SIZE  = 32,
    parameter int unsigned SAMPLE_W      = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned RESULT_DEPTH  = 8
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [SAMPLE_W-1:0]                    num_samples,
    input  logic [31:0]                            sim_time,
    input  logic [NUM_OUTPUTS*COUNTER_SIZE-1:0]    spike_counts,
    output logic                                   network_rst,
    output logic                                   network_en,
    output logic                                   sample_advance,
    output logic [SAMPLE_W-1:0]                    sample_idx,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   aborted,
`ifdef SNN_SEQ_PERF_EN
    output logic [31:0]                            stall_cycles,
`endif
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [SAMPLE_W-1:0]                    res_sample,
    output logic [clog2_min1(NUM_OUTPUTS)-1:0]     res_winner,
    output logic [COUNTER_SIZE-1:0]                res_count
);

    localparam int unsigned WINNER_W = clog2_min1(NUM_OUTPUTS);

    typedef struct packed {
        logic [SAMPLE_W-1:0]     sample;
        logic [WINNER_W-1:0]     winner;
        logic [COUNTER_SIZE-1:0] count;
    } result_t;

    seq_state_t              state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [WINNER_W-1:0]     scan_q, scan_d;
    logic [SAMPLE_W-1:0]     num_q, num_d;
    logic [31:0]             time_q, time_d;
    logic [SAMPLE_W-1:0]     idx_q, idx_d;
    logic [WINNER_W-1:0]     best_idx_q, best_idx_d;
    logic [COUNTER_SIZE-1:0] best_cnt_q, best_cnt_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;

    logic [COUNTER_SIZE-1:0] cur_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    push;
    logic                    wr_ok;
    logic                    start_acc;
    result_t                 push_data;
    result_t                 head;

    // Select the counter currently being scanned.
    always_comb begin
        cur_count = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (scan_q == WINNER_W'(i)) cur_count = spike_counts[i*COUNTER_SIZE +: COUNTER_SIZE];
        end
    end

    // FIFO handshake; a concurrent pop frees room for the push.
    always_comb begin
        pop       = !fifo_empty && res_ready;
        wr_ok     = !fifo_full || pop;
        push      = (state_q == PUSH) && !abort && wr_ok;
        start_acc = (state_q == IDLE) && start && !abort;
        push_data = '{sample: idx_q, winner: best_idx_q, count: best_cnt_q};
    end

    // Next-state and Moore outputs; abort overrides everything outside IDLE.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        scan_d         = scan_q;
        num_d          = num_q;
        time_d         = time_q;
        idx_d          = idx_q;
        best_idx_d     = best_idx_q;
        best_cnt_d     = best_cnt_q;
        done_d         = done_q;
        aborted_d      = aborted_q;
        network_rst    = 1'b0;
        network_en     = 1'b0;
        sample_advance = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    num_d     = num_samples;
                    time_d    = sim_time;
                    idx_d     = '0;
                    done_d    = 1'b0;
                    aborted_d = 1'b0;
                    cnt_d     = 32'(SETTLE_CYCLES - 1);
                    state_d   = (num_samples == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                network_rst = 1'b1;
                best_idx_d  = '0;
                best_cnt_d  = '0;
                scan_d      = '0;
                if (cnt_q == '0) begin
                    if (time_q == '0) begin
                        state_d = SCAN;
                    end else begin
                        cnt_d   = time_q - 32'd1;
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RUN: begin
                network_en = 1'b1;
                if (cnt_q == '0) state_d = SCAN;
                else             cnt_d   = cnt_q - 32'd1;
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (cur_count > best_cnt_q) begin
                    best_idx_d = scan_q;
                    best_cnt_d = cur_count;
                end
                if (scan_q == WINNER_W'(NUM_OUTPUTS - 1)) state_d = PUSH;
                else                                      scan_d  = scan_q + 1'b1;
            end
            PUSH: begin
                if (wr_ok) state_d = NEXT;
            end
            NEXT: begin
                if (idx_q == num_q - SAMPLE_W'(1)) begin
                    state_d = DONE;
                end else begin
                    sample_advance = 1'b1;
                    idx_d          = idx_q + SAMPLE_W'(1);
                    cnt_d          = 32'(SETTLE_CYCLES - 1);
                    state_d        = CLEAR;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d        = IDLE;
            network_rst    = 1'b1;
            network_en     = 1'b0;
            sample_advance = 1'b0;
            aborted_d      = 1'b1;
            done_d         = done_q;
            idx_d          = idx_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            scan_q     <= '0;
            num_q      <= '0;
            time_q     <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            num_q      <= num_d;
            time_q     <= time_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

`ifdef SNN_SEQ_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of cycles blocked in PUSH by a full FIFO.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)                                        stall_q <= '0;
        else if (start_acc)                                        stall_q <= '0;
        else if (state_q == PUSH && fifo_full && stall_q != '1)    stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`endif

    seq_result_fifo #(
        .DEPTH   (RESULT_DEPTH),
        .entry_t (result_t)
    ) u_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .wr_en   (push),
        .wr_data (push_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs; result fields read as zero while the FIFO is empty.
    always_comb begin
        sample_idx = idx_q;
        busy       = (state_q != IDLE);
        done       = done_q;
        aborted    = aborted_q;
        res_valid  = !fifo_empty;
        res_sample = fifo_empty ? '0 : head.sample;
        res_winner = fifo_empty ? '0 : head.winner;
        res_count  = fifo_empty ? '0 : head.count;
    end

endmodule

// File: tb/tb_snn_run_sequencer.sv
// tb_snn_run_sequencer: scoreboard bench for snn_run_sequencer with four
// outputs and a two-entry result FIFO.
module tb_snn_run_sequencer;

    localparam int unsigned NO = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned SW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [SW-1:0]   num_samples = '0;
    logic [31:0]     sim_time = '0;
    logic [NO*CW-1:0] spike_counts = '0;
    logic            network_rst, network_en, sample_advance;
    logic [SW-1:0]   sample_idx;
    logic            busy, done, aborted;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [SW-1:0]   res_sample;
    logic [1:0]      res_winner;
    logic [CW-1:0]   res_count;
`ifdef SNN_SEQ_PERF_EN
    logic [31:0]     stall_cycles;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int adv_cnt = 0;
    int pop_cnt = 0;
    logic [49:0] sb[$];

    snn_run_sequencer #(
        .NUM_OUTPUTS   (NO),
        .COUNTER_SIZE  (CW),
        .SAMPLE_W      (SW),
        .SETTLE_CYCLES (2),
        .RESULT_DEPTH  (2)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .start          (start),
        .abort          (abort),
        .num_samples    (num_samples),
        .sim_time       (sim_time),
        .spike_counts   (spike_counts),
        .network_rst    (network_rst),
        .network_en     (network_en),
        .sample_advance (sample_advance),
        .sample_idx     (sample_idx),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
`ifdef SNN_SEQ_PERF_EN
        .stall_cycles   (stall_cycles),
`endif
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_sample     (res_sample),
        .res_winner     (res_winner),
        .res_count      (res_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops are compared against the scoreboard, activity is counted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (network_en)     en_cnt++;
            if (network_rst)    rst_cnt++;
            if (sample_advance) adv_cnt++;
            if (res_valid && res_ready) begin
                pop_cnt++;
                if (sb.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
                else check("res_entry", {14'd0, res_sample, res_winner, res_count}, {14'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        spike_counts = {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endtask

    task automatic clear_stats();
        en_cnt = 0; rst_cnt = 0; adv_cnt = 0; pop_cnt = 0;
    endtask

    // Queue the expected entries for the first n_exp samples, then pulse start.
    task automatic start_batch(input int n, input int t, input int w, input int c, input int n_exp);
        for (int i = 0; i < n_exp; i++) sb.push_back({16'(i), 2'(w), 32'(c)});
        num_samples = SW'(n);
        sim_time    = 32'(t);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 2000) begin
            tick();
            cycles++;
        end
        if (busy) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int cyc;
        int guard;

        // Reset state
        repeat (2) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", {58'd0, network_rst, network_en, sample_advance, done, aborted, res_valid}, 64'd0);
        check("rst_idx", 64'(sample_idx), 64'd0);
        rst_n = 1'b1;
        tick();

        // One sample, tie between outputs 1 and 2 resolves to 1
        res_ready = 1'b1;
        set_counts(3, 9, 9, 1);
        clear_stats();
        start_batch(1, 10, 1, 9, 1);
        wait_idle("t1", cyc);
        repeat (2) tick();
        check("t1_en_cycles", 64'(en_cnt), 64'd10);
        check("t1_rst_cycles", 64'(rst_cnt), 64'd2);
        check("t1_done", 64'(done), 64'd1);
        check("t1_pops", 64'(pop_cnt), 64'd1);

        // Three samples with immediate draining
        set_counts(5, 0, 7, 7);
        clear_stats();
        start_batch(3, 5, 2, 7, 3);
        wait_idle("t2", cyc);
        repeat (2) tick();
        check("t2_en_cycles", 64'(en_cnt), 64'd15);
        check("t2_adv", 64'(adv_cnt), 64'd2);
        check("t2_rst_cycles", 64'(rst_cnt), 64'd6);
        check("t2_last_idx", 64'(sample_idx), 64'd2);
        check("t2_pops", 64'(pop_cnt), 64'd3);

        // Zero-sample batch
        clear_stats();
        start_batch(0, 10, 0, 0, 0);
        wait_idle("t3a", cyc);
        check("t3a_latency", 64'(cyc <= 1), 64'd1);
        check("t3a_done", 64'(done), 64'd1);
        check("t3a_no_en", 64'(en_cnt), 64'd0);
        tick();
        check("t3a_no_entry", 64'(res_valid), 64'd0);

        // Zero run time, all-zero counters
        set_counts(0, 0, 0, 0);
        clear_stats();
        start_batch(1, 0, 0, 0, 1);
        wait_idle("t3b", cyc);
        repeat (2) tick();
        check("t3b_no_en", 64'(en_cnt), 64'd0);
        check("t3b_pops", 64'(pop_cnt), 64'd1);

        // FIFO back-pressure stalls in PUSH
        res_ready = 1'b0;
        set_counts(0, 4, 0, 0);
        clear_stats();
        start_batch(4, 3, 1, 4, 4);
        repeat (60) tick();
        check("t4_stalled_busy", 64'(busy), 64'd1);
        check("t4_stalled_idx", 64'(sample_idx), 64'd2);
        check("t4_fifo_valid", 64'(res_valid), 64'd1);
`ifdef SNN_SEQ_PERF_EN
        check("t4_stall_cycles_nz", 64'(stall_cycles != 0), 64'd1);
`endif
        res_ready = 1'b1;
        wait_idle("t4", cyc);
        repeat (3) tick();
        check("t4_done", 64'(done), 64'd1);
        check("t4_pops", 64'(pop_cnt), 64'd4);

        // Abort during RUN of sample 1
        res_ready = 1'b0;
        set_counts(2, 0, 0, 0);
        clear_stats();
        start_batch(3, 20, 0, 2, 1);
        guard = 0;
        while (!(sample_idx == 1 && network_en) && guard < 500) begin
            tick();
            guard++;
        end
        check("t5_reached_run1", 64'(sample_idx == 1 && network_en), 64'd1);
        abort = 1'b1;
        #1;
        check("t5_abort_rst", 64'(network_rst), 64'd1);
        tick();
        abort = 1'b0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_aborted", 64'(aborted), 64'd1);
        check("t5_done", 64'(done), 64'd0);
        check("t5_fifo_one", 64'(res_valid && res_sample == 0), 64'd1);
        res_ready = 1'b1;
        repeat (3) tick();
        check("t5_fifo_drained", 64'(res_valid), 64'd0);
        check("t5_pops", 64'(pop_cnt), 64'd1);
        start_batch(1, 2, 0, 2, 1);
        check("t5_restart_clears", 64'(aborted), 64'd0);
        wait_idle("t5b", cyc);
        repeat (2) tick();
        check("t5b_done", 64'(done), 64'd1);

        // Asynchronous reset during SCAN of sample 1
        res_ready = 1'b0;
        set_counts(0, 0, 6, 0);
        clear_stats();
        start_batch(2, 4, 2, 6, 0);
        guard = 0;
        while (!(sample_idx == 1 && network_en) && guard < 500) begin
            tick();
            guard++;
        end
        while (network_en && guard < 500) begin
            tick();
            guard++;
        end
        check("t6_reached_scan", 64'(busy && !network_en && !network_rst && sample_idx == 1), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {58'd0, network_rst, network_en, sample_advance, done, aborted, res_valid}, 64'd0);
        check("t6_rst_busy_idx", {47'd0, busy, sample_idx}, 64'd0);
        check("t6_rst_res", {14'd0, res_sample, res_winner, res_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        res_ready = 1'b1;
        clear_stats();
        start_batch(1, 3, 2, 6, 1);
        wait_idle("t6b", cyc);
        repeat (2) tick();
        check("t6b_done", 64'(done), 64'd1);
        check("t6b_pops", 64'(pop_cnt), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
